// File: rtl/byte_mem_ctrl.sv
// Multi-cycle word load/store controller over a byte-wide memory array.
// Each accepted word is moved as four big-endian byte accesses, then a one-cycle response.
module byte_mem_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // req_ready is low from the accept until the response cycle has ended, and
  // resp_valid is a single-cycle pulse with no back-pressure.

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [23:0]         shift_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                busy_q;
  logic [31:0]         resp_rdata_q;
  logic [7:0]          mem_q [DEPTH];

  logic [ADDR_W-1:0]   byte_addr_d;
  logic [7:0]          wbyte_d;
  logic [7:0]          rbyte_d;

  assign byte_addr_d = addr_q + ADDR_W'(cnt_q);
  assign rbyte_d     = mem_q[byte_addr_d];

  // Byte 0 of the word is the most significant one (big-endian).
  always_comb begin
    wbyte_d = wdata_q[31:24];
    case (cnt_q)
      2'd0: wbyte_d = wdata_q[31:24];
      2'd1: wbyte_d = wdata_q[23:16];
      2'd2: wbyte_d = wdata_q[15:8];
      2'd3: wbyte_d = wdata_q[7:0];
      default: wbyte_d = wdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      shift_q      <= 24'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= 2'd0;
            state_q     <= XFER;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        XFER: begin
          if (!write_q) shift_q <= {shift_q[15:0], rbyte_d};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            if (!write_q) resp_rdata_q <= {shift_q, rbyte_d};
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory is never cleared; a reset arriving mid-store suppresses only the byte of that cycle.
  always_ff @(posedge clk) begin
    if (!reset && state_q == XFER && write_q) mem_q[byte_addr_d] <= wbyte_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = busy_q;
  assign dbg_data   = mem_q[dbg_addr];

endmodule

// File: doc/byte_mem_ctrl.md
# byte_mem_ctrl

Multi-cycle word-access controller for the byte-organised data memory of the MIPS datapath. Sits directly downstream of the ALU/register-file stage: it accepts a 32-bit load or store request (byte address from the ALU result, store data from register read port 2), and serialises it into four single-byte accesses of an internal byte array. Word layout is big-endian, and read words are returned through a valid pulse. Replaces the single-cycle combinational data memory when the datapath moves to a stalled/multi-cycle memory.

## Interface
- ADDR_W, 5, byte-address width; the memory holds DEPTH = 2**ADDR_W bytes, 8 bits each.

- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  controller can accept a request this cycle.
- req_write  input  1  1 = store word, 0 = load word; sampled at accept.
- req_addr  input  ADDR_W  byte address of the word's MSB byte; sampled at accept.
- req_wdata  input  32  store data; sampled at accept.
- resp_valid  output  1  one-cycle pulse: the transaction has completed.
- resp_rdata  output  32  assembled load word; valid when resp_valid is high after a load.
- busy  output  1  high whenever the FSM is not in IDLE.
- dbg_addr  input  ADDR_W  combinational debug byte-read address.
- dbg_data  output  8  mem[dbg_addr], combinational.

## Operation
- FSM states: IDLE, XFER, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid=1, accept: latch req_write, req_addr and req_wdata; set cnt=0; go to XFER.
- **XFER**
  - req_ready=0.
  - Each cycle accesses the byte at (addr_l + cnt) mod DEPTH. Address arithmetic is ADDR_W bits wide and wraps.
  - Store: mem[(addr_l+cnt)] <= wdata_l[31-8*cnt -: 8], written at the end of that cycle.
  - Load: rdata shift register <= {rdata[23:0], mem[(addr_l+cnt)]}.
  - cnt increments each cycle; after cnt=3, go to RESP.
- **RESP**
  - resp_valid=1 for exactly this cycle; req_ready=0; then go to IDLE.
- Big-endian: byte at addr_l maps to bits [31:24]; byte at addr_l+3 maps to bits [7:0].
- resp_rdata:
  - Updated only by loads.
  - Holds its value until the next load completes.
  - A store leaves it unchanged.
- No alignment check: any address is legal, and unaligned or wrapping words are serviced identically.
- Inputs are ignored while busy; changes to req_* after accept do not affect the transaction.
- Memory contents:
  - Not cleared by reset.
  - The bench preloads them through $readmemh on the internal array.
- dbg_data reflects stores from the cycle after the byte's write edge.

## Timing
- Reset values: state=IDLE, cnt=0, req_ready=1, resp_valid=0, busy=0, resp_rdata=32'h0, latched addr/wdata=0.
- Accept at posedge E0. XFER occupies the 4 cycles after E0, and RESP is the 5th cycle. resp_valid is high in the cycle after E0+4 edges. req_ready returns high in the 6th cycle after accept.
- Throughput: one word per 6 cycles with back-to-back req_valid.
- Reset asserted mid-XFER or in RESP:
  - Next state is IDLE and resp_valid=0; no response is produced.
  - Bytes already stored stay stored; there is no rollback.
- reset and req_valid together: reset wins, and no accept occurs.
- Load of a word overlapping bytes written by the preceding store returns the new bytes, because transactions are strictly sequential.

## Test plan
- Reset, then idle 3 cycles -> req_ready=1, busy=0, resp_valid=0, resp_rdata=0.
- Store 32'hDEADBEEF at addr 8 -> mem[8..11]=DE,AD,BE,EF via dbg port. resp_valid pulses exactly 5 cycles after accept; resp_rdata stays unchanged.
- Preload mem[4..7]=01,23,45,67; load addr 4 -> resp_rdata=32'h01234567 in the resp_valid cycle; req_ready is low for 5 cycles.
- Wrap: store 32'hA1B2C3D4 at addr 30 -> mem[30]=A1, mem[31]=B2, mem[0]=C3, mem[1]=D4; then load addr 30 returns 32'hA1B2C3D4.
- Unaligned overlap: store 32'h11223344 at addr 2, then load addr 3 -> 32'h223344xx, where xx is the preloaded mem[6].
- Reset mid-store: store 32'hCAFEF00D at addr 16, and assert reset in the 3rd XFER cycle.
  - mem[16]=CA and mem[17]=FE; mem[18..19] unchanged.
  - No resp_valid; req_ready=1 in the cycle after reset deasserts.
  - A subsequent load at addr 16 completes normally.
